fmdll_lock_det: RTL and testbench

- Lock detector sitting directly downstream of the frequency-multiplying DLL.
- Consumes clk_ext and the multiplied clk_out plus the M/N ratio settings.
- Measures clk_out rising edges over a window of M clk_ext periods and compares the count to N.
- Asserts lock after LOCK_CNT consecutive good windows, and drops lock after UNLOCK_CNT consecutive bad windows. System logic uses lock to gate use of clk_out.

---
 rtl/fmdll_lock_pkg.sv | 23 ++
 rtl/fmdll_edge_sync.sv | 25 ++
 rtl/fmdll_lock_det.sv | 244 ++++++++++++++++++++++++
 tb/tb_fmdll_lock_det.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmdll_lock_pkg.sv
// Shared types and defaults for the FMDLL lock detector.
// The optional clk_ext stall watchdog is enabled by defining FMDLL_LOCK_TIMEOUT_EN.
package fmdll_lock_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2,
    EVAL = 2'd3
  } state_e;

  localparam int DEF_CNT_W      = 6;
  localparam int DEF_TOL        = 0;
  localparam int DEF_LOCK_CNT   = 4;
  localparam int DEF_UNLOCK_CNT = 2;
  localparam int DEF_TIMEOUT    = 1024;

  // A divide setting of 0 behaves as a one-period window.
  function automatic logic [2:0] eff_window(input logic [1:0] m);
    return (m == 2'd0) ? 3'd1 : {1'b0, m};
  endfunction

endpackage

// File: rtl/fmdll_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// Pin-to-pulse latency is three clk_sys cycles.
module fmdll_edge_sync (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);

  logic [2:0] sync_q;
  logic       rise_q;

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      sync_q <= '0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], async_i};
      rise_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/fmdll_lock_det.sv
// Counts clk_out edges over M clk_ext periods, compares against N and tracks lock.
// Define FMDLL_LOCK_TIMEOUT_EN to add the clk_ext stall watchdog and stall flag.
module fmdll_lock_det
  import fmdll_lock_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int TOL        = DEF_TOL,
  parameter int LOCK_CNT   = DEF_LOCK_CNT,
  parameter int UNLOCK_CNT = DEF_UNLOCK_CNT,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clk_ext,
  input  logic             clk_out,
  input  logic [1:0]       M,
  input  logic [3:0]       N,
  output logic             lock,
  output logic             lock_lost,
  output logic [CNT_W-1:0] meas_cnt,
  output logic             meas_valid,
  output logic             stall
);

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W:0]   TOL_W       = (CNT_W+1)'(TOL);
  localparam logic [7:0]       LOCK_LAST   = 8'(LOCK_CNT - 1);
  localparam logic [7:0]       UNLOCK_LAST = 8'(UNLOCK_CNT - 1);

  logic ext_rise, out_rise;

  fmdll_edge_sync u_ext_sync (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .async_i (clk_ext),
    .rise_o  (ext_rise)
  );

  fmdll_edge_sync u_out_sync (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .async_i (clk_out),
    .rise_o  (out_rise)
  );

  state_e           state_q, state_d;
  logic [1:0]       m_q, m_d;
  logic [3:0]       n_q, n_d;
  logic [2:0]       win_q, win_d;
  logic [CNT_W-1:0] edges_q, edges_d;
  logic [CNT_W-1:0] meas_cnt_q, meas_cnt_d;
  logic [7:0]       good_q, good_d, bad_q, bad_d;
  logic             lock_q, lock_d;
  logic             lock_lost_q, lock_lost_d;
  logic             meas_valid_q, meas_valid_d;

`ifdef FMDLL_LOCK_TIMEOUT_EN
  localparam int             SW      = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0]  TO_LAST = SW'(TIMEOUT - 1);
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  logic          stall_q, stall_d;
`endif

  // Unsigned-safe distance between the measured count and the expected N.
  logic [CNT_W:0] cnt_ext, n_ext, diff;
  logic           good;
  assign cnt_ext = {1'b0, edges_q};
  assign n_ext   = (CNT_W+1)'(n_q);
  assign diff    = (cnt_ext >= n_ext) ? (cnt_ext - n_ext) : (n_ext - cnt_ext);
  assign good    = (edges_q != CNT_MAX) && (diff <= TOL_W);

  logic cfg_changed;
  assign cfg_changed = (M != m_q) || (N != n_q);

  always_comb begin
    state_d      = state_q;
    m_d          = m_q;
    n_d          = n_q;
    win_d        = win_q;
    edges_d      = edges_q;
    meas_cnt_d   = meas_cnt_q;
    good_d       = good_q;
    bad_d        = bad_q;
    lock_d       = lock_q;
    lock_lost_d  = 1'b0;
    meas_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (en && (N != 4'd0)) begin
          m_d     = M;
          n_d     = N;
          state_d = ARM;
        end
      end
      ARM: begin
        if (ext_rise) begin
          edges_d = CNT_W'(out_rise);
          win_d   = eff_window(m_q);
          state_d = MEAS;
        end
      end
      MEAS: begin
        if (out_rise && (edges_q != CNT_MAX)) edges_d = edges_q + 1'b1;
        if (ext_rise) begin
          if (win_q <= 3'd1) begin
            win_d   = 3'd0;
            state_d = EVAL;
          end else begin
            win_d = win_q - 3'd1;
          end
        end
      end
      EVAL: begin
        // The closing reference edge already opened the next window.
        meas_cnt_d   = edges_q;
        meas_valid_d = 1'b1;
        edges_d      = CNT_W'(out_rise);
        win_d        = eff_window(m_q);
        state_d      = MEAS;
        if (!lock_q) begin
          if (good) begin
            if (good_q >= LOCK_LAST) begin
              lock_d = 1'b1;
              good_d = 8'd0;
              bad_d  = 8'd0;
            end else begin
              good_d = good_q + 8'd1;
            end
          end else begin
            good_d = 8'd0;
          end
        end else begin
          if (!good) begin
            if (bad_q >= UNLOCK_LAST) begin
              lock_d      = 1'b0;
              lock_lost_d = 1'b1;
              good_d      = 8'd0;
              bad_d       = 8'd0;
            end else begin
              bad_d = bad_q + 8'd1;
            end
          end else begin
            bad_d = 8'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef FMDLL_LOCK_TIMEOUT_EN
    stall_d     = stall_q;
    stall_cnt_d = stall_cnt_q;
    if (ext_rise) begin
      stall_cnt_d = '0;
      stall_d     = 1'b0;
    end else if ((state_q == ARM) || (state_q == MEAS)) begin
      if (stall_cnt_q == TO_LAST) begin
        stall_cnt_d = '0;
        stall_d     = 1'b1;
        state_d     = ARM;
        lock_d      = 1'b0;
        lock_lost_d = lock_q;
        good_d      = 8'd0;
        bad_d       = 8'd0;
      end else begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end else begin
      stall_cnt_d = '0;
    end
`endif

    // Aborts take priority over everything above; an aborted window never reports.
    if (state_q != IDLE && cfg_changed) begin
      state_d      = ARM;
      lock_d       = 1'b0;
      lock_lost_d  = lock_q;
      good_d       = 8'd0;
      bad_d        = 8'd0;
      meas_cnt_d   = meas_cnt_q;
      meas_valid_d = 1'b0;
    end
    if (!en || (N == 4'd0)) begin
      state_d      = IDLE;
      lock_d       = 1'b0;
      lock_lost_d  = lock_q;
      good_d       = 8'd0;
      bad_d        = 8'd0;
      meas_cnt_d   = meas_cnt_q;
      meas_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      m_q          <= 2'd0;
      n_q          <= 4'd0;
      win_q        <= 3'd0;
      edges_q      <= '0;
      meas_cnt_q   <= '0;
      good_q       <= 8'd0;
      bad_q        <= 8'd0;
      lock_q       <= 1'b0;
      lock_lost_q  <= 1'b0;
      meas_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_q          <= m_d;
      n_q          <= n_d;
      win_q        <= win_d;
      edges_q      <= edges_d;
      meas_cnt_q   <= meas_cnt_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      lock_q       <= lock_d;
      lock_lost_q  <= lock_lost_d;
      meas_valid_q <= meas_valid_d;
    end
  end

`ifdef FMDLL_LOCK_TIMEOUT_EN
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      stall_q     <= stall_d;
    end
  end
  assign stall = stall_q;
`else
  assign stall = 1'b0;
`endif

  assign lock       = lock_q;
  assign lock_lost  = lock_lost_q;
  assign meas_cnt   = meas_cnt_q;
  assign meas_valid = meas_valid_q;

endmodule

// File: tb/tb_fmdll_lock_det.sv
// Scoreboard bench for fmdll_lock_det: two instances (TOL=0 and TOL=1) share stimulus.
// Define FMDLL_LOCK_TIMEOUT_EN to also exercise the stall watchdog.
module tb_fmdll_lock_det;
   import fmdll_lock_pkg::*;

   typedef struct {
      int cnt;
      int lock;
   } exp_t;

   logic       clkSys;
   logic       rstN;
   logic       en;
   logic       clkExt;
   logic       clkOut;
   logic [1:0] mSet;
   logic [3:0] nSet;

   logic       lock0, lockLost0, measValid0, stall0;
   logic [5:0] measCnt0;
   logic       lock1, lockLost1, measValid1, stall1;
   logic [5:0] measCnt1;

   exp_t q0[$];
   exp_t q1[$];
   int   tests = 0;
   int   fails = 0;
   int   lostCnt0 = 0;
   int   lostCnt1 = 0;

   fmdll_lock_det dut (
      .clk_sys(clkSys), .rst_n(rstN), .en(en), .clk_ext(clkExt), .clk_out(clkOut),
      .M(mSet), .N(nSet), .lock(lock0), .lock_lost(lockLost0), .meas_cnt(measCnt0),
      .meas_valid(measValid0), .stall(stall0)
   );

   fmdll_lock_det #(.TOL(1)) dutTol (
      .clk_sys(clkSys), .rst_n(rstN), .en(en), .clk_ext(clkExt), .clk_out(clkOut),
      .M(mSet), .N(nSet), .lock(lock1), .lock_lost(lockLost1), .meas_cnt(measCnt1),
      .meas_valid(measValid1), .stall(stall1)
   );

   // Free-running sampling clock, 6x faster than the fastest clk_out the bench drives
   initial clkSys = 1'b0;
   always #5 clkSys = ~clkSys;

   // Compare one value and log a FAIL line on mismatch
   task automatic checkOutput(input string name, input int actual, input int expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Monitor: counts lock_lost pulses and pops the scoreboard on each meas_valid
   task automatic monitorLoop();
      exp_t e;
      forever begin
         @(negedge clkSys);
         if (lockLost0) lostCnt0++;
         if (lockLost1) lostCnt1++;
         if (measValid0) begin
            if (q0.size() == 0) checkOutput("dut0 unexpected meas_valid", 1, 0);
            else begin
               e = q0.pop_front();
               checkOutput("dut0 meas_cnt", int'(measCnt0), e.cnt);
               checkOutput("dut0 lock", int'(lock0), e.lock);
            end
         end
         if (measValid1) begin
            if (q1.size() == 0) checkOutput("dut1 unexpected meas_valid", 1, 0);
            else begin
               e = q1.pop_front();
               checkOutput("dut1 meas_cnt", int'(measCnt1), e.cnt);
               checkOutput("dut1 lock", int'(lock1), e.lock);
            end
         end
      end
   endtask

   // One clk_ext period of 48 sys cycles holding k clk_out pulses clear of the ext edge
   task automatic extPeriod(input int k, input int nCyc);
      for (int c = 0; c < nCyc; c++) begin
         clkExt = (c < 24);
         clkOut = (c >= 4) && (((c - 4) % 6) < 3) && (((c - 4) / 6) < k);
         @(negedge clkSys);
      end
      clkOut = 1'b0;
   endtask

   // One measurement window of M periods, with the expected report pushed first
   task automatic applyStimulus(input int kPer, input int expCnt, input int expLock0, input int expLock1);
      exp_t e0, e1;
      int   mEff;
      e0.cnt = expCnt; e0.lock = expLock0;
      e1.cnt = expCnt; e1.lock = expLock1;
      q0.push_back(e0);
      q1.push_back(e1);
      mEff = (mSet == 2'd0) ? 1 : int'(mSet);
      for (int p = 0; p < mEff; p++) extPeriod(kPer, 48);
   endtask

   task automatic resetDut();
      @(negedge clkSys);
      rstN = 1'b0; en = 1'b0; clkExt = 1'b0; clkOut = 1'b0;
      repeat (3) @(negedge clkSys);
      rstN = 1'b1;
      #2;
      checkOutput("reset lock", int'(lock0), 0);
      checkOutput("reset meas_cnt", int'(measCnt0), 0);
      checkOutput("reset meas_valid", int'(measValid0), 0);
      checkOutput("reset stall", int'(stall0), 0);
      @(negedge clkSys);
   endtask

   task automatic startCfg(input logic [1:0] m, input logic [3:0] n);
      mSet = m; nSet = n; en = 1'b1;
      repeat (4) @(negedge clkSys);
   endtask

   task automatic checkDrained(input string name);
      checkOutput({name, " dut0 windows reported"}, q0.size(), 0);
      checkOutput({name, " dut1 windows reported"}, q1.size(), 0);
   endtask

   initial begin
      rstN = 1'b0; en = 1'b0; clkExt = 1'b0; clkOut = 1'b0; mSet = 2'd0; nSet = 4'd0;
      fork
         monitorLoop();
      join_none

      // M=2, N=6, clk_out at 3x: exact counts, lock on the 4th evaluation
      resetDut();
      startCfg(2'd2, 4'd6);
      applyStimulus(3, 6, 0, 0);
      applyStimulus(3, 6, 0, 0);
      applyStimulus(3, 6, 0, 0);
      applyStimulus(3, 6, 1, 1);
      applyStimulus(3, 6, 1, 1);
      extPeriod(3, 20);
      #2;
      checkDrained("m2n6");
      checkOutput("m2n6 locked", int'(lock0), 1);
      checkOutput("m2n6 no lock_lost", lostCnt0, 0);

      // N changed mid-window while locked: abort to ARM with one lock_lost
      @(negedge clkSys);
      nSet = 4'd8;
      repeat (2) @(negedge clkSys);
      #2;
      checkOutput("nchg lock_lost dut0", lostCnt0, 1);
      checkOutput("nchg lock_lost dut1", lostCnt1, 1);
      checkOutput("nchg lock dropped", int'(lock0), 0);
      checkOutput("nchg state is ARM", int'(dut.state_q), int'(ARM));
      @(negedge clkSys);
      en = 1'b0;
      repeat (2) @(negedge clkSys);
      #2;
      checkDrained("nchg");

      // M=1, N=4: lock, drop to 3x for two bad windows, restore 4x
      resetDut();
      startCfg(2'd1, 4'd4);
      applyStimulus(4, 4, 0, 0);
      applyStimulus(4, 4, 0, 0);
      applyStimulus(4, 4, 0, 0);
      applyStimulus(4, 4, 1, 1);
      applyStimulus(4, 4, 1, 1);
      applyStimulus(3, 3, 1, 1);
      applyStimulus(3, 3, 0, 1);
      applyStimulus(4, 4, 0, 1);
      applyStimulus(4, 4, 0, 1);
      applyStimulus(4, 4, 0, 1);
      applyStimulus(4, 4, 1, 1);
      extPeriod(4, 20);
      #2;
      checkDrained("relock");
      checkOutput("relock lock_lost dut0", lostCnt0, 2);
      checkOutput("relock lock_lost dut1", lostCnt1, 1);
      checkOutput("relock locked", int'(lock0), 1);
      checkOutput("relock meas_cnt", int'(measCnt0), 4);

      // Reset in the middle of a window clears every output at once
      @(negedge clkSys);
      rstN = 1'b0;
      @(negedge clkSys);
      #2;
      checkOutput("midreset lock", int'(lock0), 0);
      checkOutput("midreset meas_cnt", int'(measCnt0), 0);
      checkOutput("midreset lock_lost", int'(lockLost0), 0);
      checkOutput("midreset dut1 lock", int'(lock1), 0);

      // N=5 with 4/6 alternating: bad at TOL=0, good at TOL=1
      resetDut();
      startCfg(2'd1, 4'd5);
      applyStimulus(4, 4, 0, 0);
      applyStimulus(6, 6, 0, 0);
      applyStimulus(4, 4, 0, 0);
      applyStimulus(6, 6, 0, 1);
      applyStimulus(4, 4, 0, 1);
      extPeriod(0, 48);
      #2;
      checkDrained("tol");
      checkOutput("tol dut0 unlocked", int'(lock0), 0);
      checkOutput("tol dut1 locked", int'(lock1), 1);

      // clk_out stuck low: zero counts and no lock
      resetDut();
      startCfg(2'd1, 4'd4);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      extPeriod(0, 48);
      #2;
      checkDrained("stuck");
      checkOutput("stuck lock", int'(lock1), 0);
      checkOutput("stuck lock_lost total", lostCnt0, 2);

`ifdef FMDLL_LOCK_TIMEOUT_EN
      begin
         int stallAt;
         int lostBefore;
         stallAt = -1;
         resetDut();
         startCfg(2'd1, 4'd4);
         applyStimulus(4, 4, 0, 0);
         applyStimulus(4, 4, 0, 0);
         applyStimulus(4, 4, 0, 0);
         applyStimulus(4, 4, 1, 1);
         lostBefore = lostCnt0;
         for (int c = 0; c < 1100; c++) begin
            clkExt = 1'b1;
            clkOut = 1'b0;
            @(negedge clkSys);
            if (stall0 && stallAt < 0) stallAt = c;
         end
         #2;
         checkDrained("stall");
         checkOutput("stall asserted", int'(stall0), 1);
         checkOutput("stall timing", int'(stallAt >= 1020 && stallAt <= 1035), 1);
         checkOutput("stall lock", int'(lock0), 0);
         checkOutput("stall lock_lost", lostCnt0 - lostBefore, 1);
         @(negedge clkSys);
         extPeriod(0, 30);
         extPeriod(0, 8);
         #2;
         checkOutput("stall cleared", int'(stall0), 0);
         @(negedge clkSys);
         en = 1'b0;
      end
`endif

      repeat (4) @(negedge clkSys);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Absolute guard so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
